// File: rtl/accumulator_core_p.sv
// Parametrised scan-loadable accumulator CPU: FETCH/EXEC/HALT sequencer, carry flag,
// hardware CALL/RET return stack with sticky fault, and button/LED IO instructions.
module accumulator_core_p #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = DATA_WIDTH - 4,
    parameter int STACK_DEPTH = 2,
    parameter int LED_WIDTH   = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scan_enable,
    input  logic                 scan_in,
    output logic                 scan_out,
    input  logic                 proc_en,
    output logic                 halt,
    output logic                 fault,
    input  logic                 btn_in,
    output logic [LED_WIDTH-1:0] led_out
);

    localparam int DW    = DATA_WIDTH;
    localparam int AW    = ADDR_WIDTH;
    localparam int SD    = STACK_DEPTH;
    localparam int LW    = LED_WIDTH;
    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam int DEPTH = 1 << AW;

    localparam int O_ST      = 0;
    localparam int O_PC      = O_ST + 2;
    localparam int O_IR      = O_PC + AW;
    localparam int O_ACC     = O_IR + DW;
    localparam int O_C       = O_ACC + DW;
    localparam int O_SP      = O_C + 1;
    localparam int O_STK     = O_SP + SPW;
    localparam int O_LED     = O_STK + SD * AW;
    localparam int O_MEM     = O_LED + LW;
    localparam int O_FLT     = O_MEM + DEPTH * DW;
    localparam int CHAIN_LEN = O_FLT + 1;

    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_STA  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_LDI  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_JZ   = 4'd10;
    localparam logic [3:0] OP_JC   = 4'd11;
    localparam logic [3:0] OP_CALL = 4'd12;
    localparam logic [3:0] OP_RET  = 4'd13;
    localparam logic [3:0] OP_IO   = 4'd14;
    localparam logic [3:0] OP_HLT  = 4'd15;

    logic [1:0]     state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [DW-1:0]  ir_q, ir_d;
    logic [DW-1:0]  acc_q, acc_d;
    logic           c_q, c_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  stack_q [SD];
    logic [AW-1:0]  stack_d [SD];
    logic [LW-1:0]  led_q, led_d;
    logic [DW-1:0]  mem_q [DEPTH];
    logic [DW-1:0]  mem_d [DEPTH];
    logic           fault_q, fault_d;

    logic [CHAIN_LEN-1:0] chain_cur, chain_nxt;
    logic [3:0]           opcode;
    logic [AW-1:0]        opnd;
    logic [DW-1:0]        opnd_zx;
    logic [DW-1:0]        mem_rd;
    logic [DW:0]          sum;
    logic                 zf;

    assign opcode  = ir_q[DW-1 -: 4];
    assign opnd    = ir_q[AW-1:0];
    assign opnd_zx = DW'(opnd);
    assign mem_rd  = mem_q[opnd];
    assign zf      = (acc_q == '0);

    assign halt     = state_q[1];
    assign fault    = fault_q;
    assign led_out  = led_q;
    assign scan_out = chain_cur[CHAIN_LEN-1];

    // Whole architectural state viewed as one vector; a scan shift is a left shift by one.
    always_comb begin
        chain_cur = '0;
        chain_cur[O_ST +: 2]    = state_q;
        chain_cur[O_PC +: AW]   = pc_q;
        chain_cur[O_IR +: DW]   = ir_q;
        chain_cur[O_ACC +: DW]  = acc_q;
        chain_cur[O_C]          = c_q;
        chain_cur[O_SP +: SPW]  = sp_q;
        for (int i = 0; i < SD; i++) begin
            chain_cur[O_STK + i * AW +: AW] = stack_q[i];
        end
        chain_cur[O_LED +: LW]  = led_q;
        for (int i = 0; i < DEPTH; i++) begin
            chain_cur[O_MEM + i * DW +: DW] = mem_q[i];
        end
        chain_cur[O_FLT]        = fault_q;
        chain_nxt = {chain_cur[CHAIN_LEN-2:0], scan_in};
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        c_d     = c_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        led_d   = led_q;
        mem_d   = mem_q;
        fault_d = fault_q;
        sum     = '0;

        if (scan_enable) begin
            state_d = chain_nxt[O_ST +: 2];
            pc_d    = chain_nxt[O_PC +: AW];
            ir_d    = chain_nxt[O_IR +: DW];
            acc_d   = chain_nxt[O_ACC +: DW];
            c_d     = chain_nxt[O_C];
            sp_d    = chain_nxt[O_SP +: SPW];
            for (int i = 0; i < SD; i++) begin
                stack_d[i] = chain_nxt[O_STK + i * AW +: AW];
            end
            led_d   = chain_nxt[O_LED +: LW];
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = chain_nxt[O_MEM + i * DW +: DW];
            end
            fault_d = chain_nxt[O_FLT];
        end else if (proc_en) begin
            case (state_q)
                ST_FETCH: begin
                    ir_d    = mem_q[pc_q];
                    pc_d    = pc_q + AW'(1);
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    case (opcode)
                        OP_LDA:  acc_d = mem_rd;
                        OP_STA:  mem_d[opnd] = acc_q;
                        OP_ADD: begin
                            sum          = {1'b0, acc_q} + {1'b0, mem_rd};
                            {c_d, acc_d} = sum;
                        end
                        OP_SUB: begin
                            acc_d = acc_q - mem_rd;
                            c_d   = (acc_q < mem_rd);
                        end
                        OP_AND:  acc_d = acc_q & mem_rd;
                        OP_OR:   acc_d = acc_q | mem_rd;
                        OP_XOR:  acc_d = acc_q ^ mem_rd;
                        OP_ADDI: begin
                            sum          = {1'b0, acc_q} + {1'b0, opnd_zx};
                            {c_d, acc_d} = sum;
                        end
                        OP_LDI:  acc_d = opnd_zx;
                        OP_JMP:  pc_d = opnd;
                        OP_JZ:   if (zf) pc_d = opnd;
                        OP_JC:   if (c_q) pc_d = opnd;
                        OP_CALL: begin
                            if (sp_q < SP_FULL) begin
                                // pc_q already points past the CALL, so it is the return address.
                                for (int i = 0; i < SD; i++) begin
                                    if (sp_q == SPW'(i)) stack_d[i] = pc_q;
                                end
                                sp_d = sp_q + SPW'(1);
                                pc_d = opnd;
                            end else begin
                                fault_d = 1'b1;
                                state_d = ST_HALT;
                            end
                        end
                        OP_RET: begin
                            if (sp_q != '0) begin
                                for (int i = 0; i < SD; i++) begin
                                    if (sp_q == SPW'(i + 1)) pc_d = stack_q[i];
                                end
                                sp_d = sp_q - SPW'(1);
                            end else begin
                                fault_d = 1'b1;
                                state_d = ST_HALT;
                            end
                        end
                        OP_IO: begin
                            if (opnd == AW'(0)) acc_d = DW'(btn_in);
                            else if (opnd == AW'(1)) led_d = acc_q[LW-1:0];
                        end
                        OP_HLT:  state_d = ST_HALT;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            sp_q    <= '0;
            for (int i = 0; i < SD; i++) stack_q[i] <= '0;
            led_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            sp_q    <= sp_d;
            stack_q <= stack_d;
            led_q   <= led_d;
            mem_q   <= mem_d;
            fault_q <= fault_d;
        end
    end

endmodule
